load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the RV32I ALU. Takes the effective address computed by the
//  ALU for LB/LH/LW/LBU/LHU/SB/SH/SW, checks alignment, and drives a valid/ready word-wide data bus
//  with byte strobes. Returns sign/zero-extended load data, or a fault, to writeback over a
//  valid/ready response channel. One operation is in flight at a time.
// PARAMETERS
//  TIMEOUT  255  bus cycles waited for mem_ready before faulting; 0 = wait forever
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  req_valid  in   1   execute stage presents a memory op
//  req_ready  out  1   unit can accept (high only in IDLE)
//  req_store  in   1   instruction[5]: 1 store, 0 load
//  req_funct3 in   3   instruction[14:12]: size/sign
//  req_addr   in   32  ALU result (effective byte address)
//  req_wdata  in   32  rs2 value for stores
//  req_rd     in   5   destination register for loads
//  mem_valid  out  1   bus request valid
//  mem_ready  in   1   bus accepts/completes request this cycle
//  mem_addr   out  32  {addr[31:2],2'b00}
//  mem_we     out  1   1 = write
//  mem_wstrb  out  4   byte lane enables, 0 for loads
//  mem_wdata  out  32  lane-replicated store data
//  mem_rdata  in   32  read word, valid when mem_valid&&mem_ready&&!mem_we
//  rsp_valid  out  1   response to writeback
//  rsp_ready  in   1   writeback accepts response
//  rsp_rd     out  5   req_rd for loads, 0 for stores and faults
//  rsp_data   out  32  extended load data; 0 for stores and faults
//  rsp_fault  out  1   op aborted
//  rsp_cause  out  2   00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3
// BEHAVIOUR
//  Reset: state IDLE, every output 0 except req_ready=1; timeout counter 0. Reset asserted
//   mid-op abandons it: mem_valid and rsp_valid fall immediately, no response is produced.
//  FSM IDLE -> BUS -> RESP -> IDLE; fault skips BUS (IDLE -> RESP).
//  IDLE: req_ready=1. On req_valid, latch all req_* fields. Legality: loads funct3 in
//   {000,001,010,100,101}, stores in {000,001,010}; else cause 11. Alignment: half needs addr[0]=0,
//   word needs addr[1:0]=0; else cause 01 (illegal is checked first). Fault -> RESP; else -> BUS.
//  BUS: mem_valid=1; mem_addr/we/wstrb/wdata held stable until handshake. Strobes: byte
//   1<<addr[1:0]; half addr[1]?1100:0011; word 1111. wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}.
//   On mem_valid&&mem_ready, a load latches extracted data: byte = rdata[8*addr[1:0]+:8],
//   half = rdata[16*addr[1]+:16]; funct3[2]=0 sign-extends, 1 zero-extends. Go RESP, mem_valid=0.
//   Counter increments each BUS cycle without mem_ready; when it equals TIMEOUT (TIMEOUT!=0),
//   drop mem_valid, cause 10, go RESP. A mem_ready arriving in that same cycle wins (no fault).
//  RESP: rsp_valid=1, rsp_* held stable until rsp_ready; then IDLE, counter cleared.
//  Latency: req accepted cycle 0, mem_valid cycle 1, rsp_valid cycle after mem handshake
//   (minimum 2). Fault response is visible at cycle 1. Peak throughput is one op per 3 cycles.
//  req_ready is registered state decode only, never combinational from rsp_ready or mem_ready.
// TESTING
//  LW addr 0x1000, rdata 0xDEADBEEF, ready cycle 1 -> mem_addr 0x1000, wstrb 0; rsp_data 0xDEADBEEF cycle 2
//  LB addr 0x1003, rdata 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU 0x1002 -> 0x00008011
//  SB addr 0x2001 d=0x000000A5 -> wstrb 0010, wdata 0xA5A5A5A5, we=1; rsp_rd 0, no fault
//  LH addr 0x3001 -> no mem_valid, rsp_fault=1 cause 01 at cycle 1; store funct3 100 -> cause 11
//  TIMEOUT=4, mem_ready never -> mem_valid high exactly 4 cycles, then rsp cause 10
//  rsp_ready held low 5 cycles -> rsp_* stable, req_ready 0; rst_n low mid-BUS -> all outputs 0

Source files
------------

// File: rtl/load_store_unit_if.sv
// Signal bundle between execute, the load/store unit, the data bus and writeback.
// The slave modport is the load/store unit's view; master is the surrounding pipeline/bus.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic [1:0]  rsp_cause;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_ready, mem_rdata, rsp_ready,
    output req_ready, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output rsp_valid, rsp_rd, rsp_data, rsp_fault, rsp_cause
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output mem_ready, mem_rdata, rsp_ready,
    input  req_ready, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  rsp_valid, rsp_rd, rsp_data, rsp_fault, rsp_cause
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory stage: checks legality/alignment, runs one word-bus transaction with byte
// strobes and a bounded wait, then returns extended load data or a fault to writeback.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } cause_t;

  localparam int unsigned   CW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);

  state_t        state_q, state_nxt;
  logic          store_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [4:0]    rd_q;
  logic [31:0]   data_q;
  cause_t        cause_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;

  cause_t        req_cause;
  logic          accept;
  logic          handshake;
  logic          timeout_hit;
  logic [31:0]   load_ext;
  logic          bus_active;
  logic          resp_active;

  assign cnt_inc = cnt_q + 1'b1;

  // Illegal encodings take priority over misalignment.
  // NOTE: every signal driven from always_comb gets a default first, so no path infers a latch.
  always_comb begin
    req_cause = CAUSE_NONE;
    if (bus.req_store ? (bus.req_funct3[2] || bus.req_funct3[1:0] == 2'b11)
                      : (bus.req_funct3[1:0] == 2'b11 || bus.req_funct3 == 3'b110))
      req_cause = CAUSE_ILLEGAL;
    else if ((bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
             (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00))
      req_cause = CAUSE_MISALIGN;
  end

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_q;
    accept      = 1'b0;
    handshake   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = (req_cause != CAUSE_NONE) ? RESP : BUS;
        end
      end
      BUS: begin
        // A ready in the final allowed cycle beats the timeout.
        if (bus.mem_ready) begin
          handshake = 1'b1;
          state_nxt = RESP;
        end else if ((TIMEOUT != 0) && (cnt_inc == TIMEOUT_VAL)) begin
          timeout_hit = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    logic [31:0] shifted;
    logic [15:0] half;
    logic        sext;
    shifted  = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    half     = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    sext     = ~funct3_q[2];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{sext & half[15]}}, half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      cause_q  <= CAUSE_NONE;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        store_q  <= bus.req_store;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        rd_q     <= bus.req_rd;
        data_q   <= '0;
        cause_q  <= req_cause;
        cnt_q    <= '0;
      end
      if (handshake) begin
        if (!store_q) data_q <= load_ext;
      end else if (timeout_hit) begin
        cause_q <= CAUSE_TIMEOUT;
      end else if (state_q == BUS) begin
        cnt_q <= cnt_inc;
      end
      if (state_q == RESP && bus.rsp_ready) cnt_q <= '0;
    end
  end

  assign bus_active  = (state_q == BUS);
  assign resp_active = (state_q == RESP);

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_valid = bus_active;
  assign bus.mem_addr  = bus_active ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_we    = bus_active & store_q;

  always_comb begin
    bus.mem_wstrb = 4'b0000;
    bus.mem_wdata = 32'h0;
    if (bus_active && store_q) begin
      case (funct3_q[1:0])
        2'b00: begin
          bus.mem_wstrb = 4'b0001 << addr_q[1:0];
          bus.mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          bus.mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
          bus.mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          bus.mem_wstrb = 4'b1111;
          bus.mem_wdata = wdata_q;
        end
      endcase
    end
  end

  // Stores and faults report rd 0 and data 0; data_q is cleared on every accept.
  assign bus.rsp_valid = resp_active;
  assign bus.rsp_fault = resp_active && (cause_q != CAUSE_NONE);
  assign bus.rsp_cause = resp_active ? cause_q : CAUSE_NONE;
  assign bus.rsp_rd    = (resp_active && !store_q && cause_q == CAUSE_NONE) ? rd_q : 5'd0;
  assign bus.rsp_data  = resp_active ? data_q : 32'h0;

endmodule
